// File: rtl/parking_lot_controller_if.sv
// Gate sensor / readout bundle for the parking lot controller.
// The master side is the sensors and host; the slave side is the controller.
interface parking_lot_controller_if;
  logic        enter_req;
  logic        enter_done;
  logic        exit_req;
  logic        exit_done;
  logic        hour_tick;
  logic [2:0]  rd_addr;
  logic        enter_open;
  logic        exit_open;
  logic        full;
  logic [7:0]  occupancy;
  logic [2:0]  hour;
  logic        day_end;
  logic [15:0] car_in;
  logic [15:0] rd_data;

  modport master (
    output enter_req, enter_done, exit_req, exit_done, hour_tick, rd_addr,
    input  enter_open, exit_open, full, occupancy, hour, day_end, car_in, rd_data
  );

  modport slave (
    input  enter_req, enter_done, exit_req, exit_done, hour_tick, rd_addr,
    output enter_open, exit_open, full, occupancy, hour, day_end, car_in, rd_data
  );
endinterface

// File: rtl/parking_lot_controller.sv
// Entry/exit gate sequencing, occupancy tracking, and an 8-hour business day
// with per-hour entry counts readable by the host.
module parking_lot_controller #(
  parameter int CAPACITY = 3,
  parameter int TIMEOUT  = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  parking_lot_controller_if.slave bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {E_IDLE, E_OPEN, E_CLOSE} entry_state_t;
  typedef enum logic [1:0] {X_IDLE, X_OPEN, X_CLOSE} exit_state_t;

  entry_state_t e_state, e_next;
  exit_state_t  x_state, x_next;
  logic [CW-1:0] e_cnt, x_cnt;
  logic [7:0]    occupancy_q;
  logic [15:0]   car_in_q;
  logic [15:0]   rd_data_q;
  logic [15:0]   hour_cnt [8];
  logic [2:0]    hour_q;
  logic          day_end_q;
  logic          full_w;
  logic          enter_acc;
  logic          exit_acc;

  assign full_w    = (occupancy_q == 8'(CAPACITY));
  assign enter_acc = (e_state == E_OPEN) && bus.enter_done;
  assign exit_acc  = (x_state == X_OPEN) && bus.exit_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_state <= E_IDLE;
      x_state <= X_IDLE;
    end else begin
      e_state <= e_next;
      x_state <= x_next;
    end
  end

  always_comb begin
    e_next = e_state;
    x_next = x_state;
    case (e_state)
      E_IDLE:  if (bus.enter_req && !full_w && !day_end_q) e_next = E_OPEN;
      E_OPEN:  if (bus.enter_done || e_cnt == T_LAST) e_next = E_CLOSE;
      E_CLOSE: e_next = E_IDLE;
      default: e_next = E_IDLE;
    endcase
    case (x_state)
      X_IDLE:  if (bus.exit_req && occupancy_q != 8'd0) x_next = X_OPEN;
      X_OPEN:  if (bus.exit_done || x_cnt == T_LAST) x_next = X_CLOSE;
      X_CLOSE: x_next = X_IDLE;
      default: x_next = X_IDLE;
    endcase
  end

  // Open timers count cycles spent in OPEN; they sit at zero in every other state.
  always_ff @(posedge clk) begin
    if (reset || e_state != E_OPEN) e_cnt <= '0;
    else                            e_cnt <= e_cnt + 1'b1;
    if (reset || x_state != X_OPEN) x_cnt <= '0;
    else                            x_cnt <= x_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy_q <= 8'd0;
      car_in_q    <= 16'd0;
      rd_data_q   <= 16'd0;
      hour_q      <= 3'd0;
      day_end_q   <= 1'b0;
      for (int i = 0; i < 8; i++) hour_cnt[i] <= 16'd0;
    end else begin
      case ({enter_acc, exit_acc})
        2'b10:   occupancy_q <= occupancy_q + 8'd1;
        2'b01:   occupancy_q <= occupancy_q - 8'd1;
        default: occupancy_q <= occupancy_q;
      endcase
      // Entries are credited to the hour held before any tick on this edge.
      if (enter_acc && car_in_q != 16'hFFFF) car_in_q <= car_in_q + 16'd1;
      if (enter_acc && hour_cnt[hour_q] != 16'hFFFF)
        hour_cnt[hour_q] <= hour_cnt[hour_q] + 16'd1;
      rd_data_q <= hour_cnt[bus.rd_addr];
      if (bus.hour_tick && !day_end_q) begin
        if (hour_q == 3'd7) day_end_q <= 1'b1;
        else                hour_q    <= hour_q + 3'd1;
      end
    end
  end

  assign bus.enter_open = (e_state == E_OPEN);
  assign bus.exit_open  = (x_state == X_OPEN);
  assign bus.full       = full_w;
  assign bus.occupancy  = occupancy_q;
  assign bus.hour       = hour_q;
  assign bus.day_end    = day_end_q;
  assign bus.car_in     = car_in_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_parking_lot_controller.sv
// Self-checking bench for parking_lot_controller: directed scenarios plus a
// randomized run compared against a gate/occupancy model held in the bench.
module tb_parking_lot_controller;
  localparam int CAPACITY = 3;
  localparam int TIMEOUT  = 50;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  parking_lot_controller_if bus ();

  parking_lot_controller #(.CAPACITY(CAPACITY), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each gate is either open (with an age), cooling down for
  // one cycle after closing, or ready; counts are plain integers.
  bit m_e_open, m_e_cool, m_x_open, m_x_cool, m_day_end;
  int m_e_age, m_x_age, m_occ, m_car_in, m_hour, m_rd;
  int m_hc[8];

  task automatic model_step();
    bit acc_in, acc_out, de_old;
    int occ_old;
    if (reset) begin
      m_e_open = 0; m_e_cool = 0; m_x_open = 0; m_x_cool = 0; m_day_end = 0;
      m_e_age = 0; m_x_age = 0; m_occ = 0; m_car_in = 0; m_hour = 0; m_rd = 0;
      foreach (m_hc[i]) m_hc[i] = 0;
      return;
    end
    acc_in  = m_e_open && bus.enter_done;
    acc_out = m_x_open && bus.exit_done;
    occ_old = m_occ;
    de_old  = m_day_end;
    m_rd    = m_hc[bus.rd_addr];
    m_occ   = m_occ + int'(acc_in) - int'(acc_out);
    if (acc_in) begin
      if (m_car_in < 65535) m_car_in++;
      if (m_hc[m_hour] < 65535) m_hc[m_hour]++;
    end
    if (m_e_open) begin
      if (bus.enter_done || m_e_age == TIMEOUT - 1) begin m_e_open = 0; m_e_cool = 1; end
      else m_e_age++;
    end else if (m_e_cool) m_e_cool = 0;
    else if (bus.enter_req && occ_old != CAPACITY && !de_old) begin m_e_open = 1; m_e_age = 0; end
    if (m_x_open) begin
      if (bus.exit_done || m_x_age == TIMEOUT - 1) begin m_x_open = 0; m_x_cool = 1; end
      else m_x_age++;
    end else if (m_x_cool) m_x_cool = 0;
    else if (bus.exit_req && occ_old != 0) begin m_x_open = 1; m_x_age = 0; end
    if (bus.hour_tick && !de_old) begin
      if (m_hour < 7) m_hour++;
      else m_day_end = 1;
    end
  endtask

  task automatic step_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.enter_req = 0; bus.enter_done = 0; bus.exit_req = 0; bus.exit_done = 0;
    bus.hour_tick = 0; bus.rd_addr = 3'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step_cycle();
    reset = 0;
  endtask

  task automatic admit_car();
    bus.enter_req = 1;
    for (int i = 0; i < 10 && bus.enter_open !== 1'b1; i++) step_cycle();
    tests_run++;
    if (bus.enter_open !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL admit_wait: enter_open=%b required 1", bus.enter_open);
    end
    bus.enter_req  = 0;
    bus.enter_done = 1;
    step_cycle();
    bus.enter_done = 0;
  endtask

  task automatic release_car();
    bus.exit_req = 1;
    for (int i = 0; i < 10 && bus.exit_open !== 1'b1; i++) step_cycle();
    tests_run++;
    if (bus.exit_open !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL release_wait: exit_open=%b required 1", bus.exit_open);
    end
    bus.exit_req  = 0;
    bus.exit_done = 1;
    step_cycle();
    bus.exit_done = 0;
  endtask

  task automatic pulse_tick();
    bus.hour_tick = 1;
    step_cycle();
    bus.hour_tick = 0;
  endtask

  task automatic test_reset();
    logic [15:0] got [8];
    string nm [8] = '{"enter_open", "exit_open", "occupancy", "full",
                      "hour", "day_end", "car_in", "rd_data"};
    do_reset();
    got = '{16'(bus.enter_open), 16'(bus.exit_open), 16'(bus.occupancy), 16'(bus.full),
            16'(bus.hour), 16'(bus.day_end), bus.car_in, bus.rd_data};
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got[i] !== 16'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_%s: got %0h required 0", nm[i], got[i]);
      end
    end
  endtask

  task automatic test_basic_entry();
    do_reset();
    bus.enter_req = 1;
    step_cycle();
    tests_run++;
    if (bus.enter_open !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL basic_open: got %b required 1", bus.enter_open);
    end
    bus.enter_req  = 0;
    bus.enter_done = 1;
    step_cycle();
    bus.enter_done = 0;
    tests_run += 3;
    if (bus.occupancy !== 8'd1) begin
      tests_failed++; $display("[TB] FAIL basic_occ: got %0d required 1", bus.occupancy);
    end
    if (bus.car_in !== 16'd1) begin
      tests_failed++; $display("[TB] FAIL basic_car_in: got %0d required 1", bus.car_in);
    end
    if (bus.enter_open !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL basic_close: got %b required 0", bus.enter_open);
    end
    bus.rd_addr = 3'd0;
    step_cycle();
    tests_run++;
    if (bus.rd_data !== 16'd1) begin
      tests_failed++; $display("[TB] FAIL basic_hour0: got %0d required 1", bus.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_seq [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    bus.enter_req = 1;
    step_cycle();
    bus.enter_done = 1;
    step_cycle();
    bus.enter_done = 0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus.enter_open !== exp_seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL b2b_step%0d: got %b required %b", i, bus.enter_open, exp_seq[i]);
      end
      if (i < 2) step_cycle();
    end
    bus.enter_req  = 0;
    bus.enter_done = 1;
    step_cycle();
    bus.enter_done = 0;
    tests_run++;
    if (bus.occupancy !== 8'd2) begin
      tests_failed++; $display("[TB] FAIL b2b_occ: got %0d required 2", bus.occupancy);
    end
  endtask

  task automatic test_fill();
    bit opened;
    do_reset();
    for (int i = 0; i < CAPACITY; i++) admit_car();
    step_cycle();
    tests_run += 2;
    if (bus.full !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL fill_full: got %b required 1", bus.full);
    end
    if (bus.occupancy !== 8'(CAPACITY)) begin
      tests_failed++; $display("[TB] FAIL fill_occ: got %0d required %0d", bus.occupancy, CAPACITY);
    end
    bus.enter_req = 1;
    opened = 0;
    for (int i = 0; i < 20; i++) begin
      step_cycle();
      if (bus.enter_open !== 1'b0) opened = 1;
    end
    tests_run++;
    if (opened) begin
      tests_failed++; $display("[TB] FAIL fill_blocked: gate opened=1 required 0");
    end
    release_car();
    tests_run += 2;
    if (bus.full !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL fill_unfull: got %b required 0", bus.full);
    end
    if (bus.occupancy !== 8'(CAPACITY - 1)) begin
      tests_failed++; $display("[TB] FAIL fill_exit_occ: got %0d required %0d", bus.occupancy, CAPACITY - 1);
    end
    step_cycle();
    tests_run++;
    if (bus.enter_open !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL fill_reopen: got %b required 1", bus.enter_open);
    end
    bus.enter_req = 0;
    do_reset();
  endtask

  task automatic test_timeout();
    int open_cycles;
    do_reset();
    admit_car();
    bus.enter_req = 1;
    for (int i = 0; i < 10 && bus.enter_open !== 1'b1; i++) step_cycle();
    bus.enter_req = 0;
    open_cycles = (bus.enter_open === 1'b1) ? 1 : 0;
    for (int i = 0; i < TIMEOUT + 20 && bus.enter_open === 1'b1; i++) begin
      step_cycle();
      if (bus.enter_open === 1'b1) open_cycles++;
    end
    tests_run += 3;
    if (open_cycles != TIMEOUT) begin
      tests_failed++; $display("[TB] FAIL timeout_len: got %0d required %0d", open_cycles, TIMEOUT);
    end
    if (bus.occupancy !== 8'd1) begin
      tests_failed++; $display("[TB] FAIL timeout_occ: got %0d required 1", bus.occupancy);
    end
    if (bus.car_in !== 16'd1) begin
      tests_failed++; $display("[TB] FAIL timeout_car_in: got %0d required 1", bus.car_in);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    admit_car();
    admit_car();
    bus.enter_req = 1;
    bus.exit_req  = 1;
    for (int i = 0; i < 10 && !(bus.enter_open === 1'b1 && bus.exit_open === 1'b1); i++)
      step_cycle();
    bus.enter_req  = 0;
    bus.exit_req   = 0;
    bus.enter_done = 1;
    bus.exit_done  = 1;
    step_cycle();
    bus.enter_done = 0;
    bus.exit_done  = 0;
    tests_run += 3;
    if (bus.occupancy !== 8'd2) begin
      tests_failed++; $display("[TB] FAIL simul_occ: got %0d required 2", bus.occupancy);
    end
    if (bus.car_in !== 16'd3) begin
      tests_failed++; $display("[TB] FAIL simul_car_in: got %0d required 3", bus.car_in);
    end
    if (bus.enter_open !== 1'b0 || bus.exit_open !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL simul_close: got %b%b required 00", bus.enter_open, bus.exit_open);
    end
  endtask

  task automatic test_hours();
    logic [15:0] exp_rd [4] = '{16'd2, 16'd0, 16'd0, 16'd1};
    bit opened;
    do_reset();
    admit_car();
    admit_car();
    for (int i = 0; i < 3; i++) pulse_tick();
    admit_car();
    for (int i = 0; i < 5; i++) pulse_tick();
    tests_run += 3;
    if (bus.hour !== 3'd7) begin
      tests_failed++; $display("[TB] FAIL hours_hour: got %0d required 7", bus.hour);
    end
    if (bus.day_end !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL hours_day_end: got %b required 1", bus.day_end);
    end
    if (bus.car_in !== 16'd3) begin
      tests_failed++; $display("[TB] FAIL hours_car_in: got %0d required 3", bus.car_in);
    end
    bus.enter_req = 1;
    opened = 0;
    for (int i = 0; i < 10; i++) begin
      step_cycle();
      if (bus.enter_open !== 1'b0) opened = 1;
    end
    bus.enter_req = 0;
    tests_run++;
    if (opened) begin
      tests_failed++; $display("[TB] FAIL hours_entry_blocked: gate opened=1 required 0");
    end
    release_car();
    tests_run++;
    if (bus.occupancy !== 8'd2) begin
      tests_failed++; $display("[TB] FAIL hours_exit: got %0d required 2", bus.occupancy);
    end
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 3'(a);
      step_cycle();
      tests_run++;
      if (bus.rd_data !== exp_rd[a]) begin
        tests_failed++;
        $display("[TB] FAIL hours_rd%0d: got %0d required %0d", a, bus.rd_data, exp_rd[a]);
      end
    end
    bus.rd_addr = 3'd0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] got [8];
    string nm [8] = '{"enter_open", "exit_open", "occupancy", "full",
                      "hour", "day_end", "car_in", "rd_data"};
    do_reset();
    admit_car();
    admit_car();
    pulse_tick();
    bus.enter_req = 1;
    for (int i = 0; i < 10 && bus.enter_open !== 1'b1; i++) step_cycle();
    bus.enter_req  = 0;
    bus.rd_addr    = 3'd0;
    reset          = 1;
    bus.enter_done = 1;
    step_cycle();
    reset          = 0;
    bus.enter_done = 0;
    got = '{16'(bus.enter_open), 16'(bus.exit_open), 16'(bus.occupancy), 16'(bus.full),
            16'(bus.hour), 16'(bus.day_end), bus.car_in, bus.rd_data};
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got[i] !== 16'd0) begin
        tests_failed++;
        $display("[TB] FAIL midreset_%s: got %0h required 0", nm[i], got[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] got [8];
    logic [15:0] exp_v [8];
    string nm [8] = '{"enter_open", "exit_open", "occupancy", "full",
                      "hour", "day_end", "car_in", "rd_data"};
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      bus.enter_req  = 1'($urandom_range(0, 1));
      bus.enter_done = ($urandom_range(0, 3) == 0);
      bus.exit_req   = 1'($urandom_range(0, 1));
      bus.exit_done  = ($urandom_range(0, 3) == 0);
      bus.hour_tick  = ($urandom_range(0, 199) == 0);
      bus.rd_addr    = 3'($urandom_range(0, 7));
      reset          = ($urandom_range(0, 499) == 0);
      step_cycle();
      got = '{16'(bus.enter_open), 16'(bus.exit_open), 16'(bus.occupancy), 16'(bus.full),
              16'(bus.hour), 16'(bus.day_end), bus.car_in, bus.rd_data};
      exp_v = '{16'(m_e_open), 16'(m_x_open), 16'(m_occ), 16'(m_occ == CAPACITY),
                16'(m_hour), 16'(m_day_end), 16'(m_car_in), 16'(m_rd)};
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got[i] !== exp_v[i]) begin
          tests_failed++;
          $display("[TB] FAIL rand_%s cycle %0d: got %0h required %0h", nm[i], n, got[i], exp_v[i]);
        end
      end
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1;
    clear_inputs();
    test_reset();
    test_basic_entry();
    test_back_to_back();
    test_fill();
    test_timeout();
    test_simultaneous();
    test_hours();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/parking_lot_controller.md
# parking_lot_controller

Sequences the parking lot's entry and exit gates, holds live occupancy against a fixed capacity, and schedules the 8-hour business day. It generates the `full` qualifier and counts accepted entries, both overall and per hour, into an 8-entry buffer that host logic can read. It sits between the gate sensors and the display/readout logic.

## Interface
- `CAPACITY`, default 3: number of spaces; legal range 1..255.
- `TIMEOUT`, default 50: cycles a gate may stay open without a pass-through before it closes with no count; legal range ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high. Clears all state.
- `enter_req` input 1: level; a car is waiting at the entry gate.
- `enter_done` input 1: one-cycle pulse; the car has passed the entry gate.
- `exit_req` input 1: level; a car is waiting at the exit gate.
- `exit_done` input 1: one-cycle pulse; the car has passed the exit gate.
- `hour_tick` input 1: one-cycle pulse; advances the hour.
- `rd_addr` input 3: hour index for readout.
- `enter_open` output 1: entry gate open.
- `exit_open` output 1: exit gate open.
- `full` output 1: high when occupancy == CAPACITY.
- `occupancy` output 8: cars currently in the lot.
- `hour` output 3: current hour, 0..7.
- `day_end` output 1: the business day is over; entries are blocked.
- `car_in` output 16: total entries accepted today.
- `rd_data` output 16: entries accepted in hour `rd_addr`; registered.

## Operation
- **Entry FSM** has three states: E_IDLE, E_OPEN, E_CLOSE.
  - E_IDLE → E_OPEN when `enter_req` is high, `full` is low and `day_end` is low.
  - E_OPEN → E_CLOSE on `enter_done`. The count is accepted: `occupancy` +1, `car_in` +1 and `hour_cnt[hour]` +1.
  - E_OPEN → E_CLOSE when the open counter reaches TIMEOUT−1. No count is made.
  - E_CLOSE → E_IDLE unconditionally. This gives one closed cycle between cars.
- **Exit FSM** has the same structure (X_IDLE, X_OPEN, X_CLOSE).
  - Opening requires `exit_req` high and `occupancy` != 0.
  - `exit_done` decrements `occupancy`.
  - Timeout behaves as for the entry FSM.
  - Exit is not blocked by `day_end`.
- The two FSMs run concurrently with independent timeout counters.
- `enter_done` or `exit_done` arriving while the matching FSM is not in its OPEN state is ignored.
- Only one car can be in the entry gate at a time and opening requires `!full`, so `occupancy` never exceeds CAPACITY.
- **Same-cycle entry and exit**: an accepted entry and an accepted exit in the same cycle leave `occupancy` unchanged. `car_in` and `hour_cnt` still increment.
- **Hour scheduler**:
  - `hour_tick` with `hour` < 7: `hour` +1.
  - `hour_tick` with `hour` == 7: `day_end` is set and `hour` holds at 7.
  - Further ticks have no effect until reset.
- If an accepted entry coincides with `hour_tick`, the entry is credited to the old hour.
- If the entry FSM is in E_OPEN when `day_end` sets, it completes normally: `enter_done` is still counted, credited to hour 7.
- `car_in` and each `hour_cnt` saturate at 0xFFFF. `occupancy` is computed 8-bit unsigned.
- `full` is combinational from `occupancy`.

## Timing
- **Reset values**:
  - FSMs in E_IDLE and X_IDLE; `enter_open` and `exit_open` 0.
  - `occupancy`, `car_in` and all 8 `hour_cnt` entries 0.
  - `hour` 0, `day_end` 0, `rd_data` 0.
  - `full` 0, since CAPACITY ≥ 1.
- `enter_open` and `exit_open` are registered and equal to "FSM in OPEN". They rise on the first edge on which the open condition is sampled true, i.e. one cycle after the request.
- Counters update on the edge that samples `enter_done` or `exit_done`. `enter_open` falls on that same edge.
- A request that stays high reopens the gate two cycles after the previous close edge (the E_CLOSE cycle, then E_IDLE).
- `rd_data` returns `hour_cnt[rd_addr]` as held before this edge, with 1-cycle latency. A read that coincides with an update returns the pre-update value.
- Reset asserted mid-operation overrides all inputs on that edge: gates close and counts clear. A `enter_done` in the reset cycle is discarded.

## Test plan
- **Basic entry**: reset, then `enter_req`=1. Check `enter_open`=1 one cycle later. Pulse `enter_done`: `occupancy`=1, `car_in`=1, `hour_cnt[0]`=1, gate closes.
- **Fill to capacity (CAPACITY=3)**: admit 3 cars. Check `full`=1. With `enter_req` held high for 20 cycles, `enter_open` stays 0. One exit → `full`=0 and the entry gate reopens.
- **Timeout**: open the entry gate and withhold `enter_done` for 50 cycles. Check `enter_open` falls after exactly TIMEOUT cycles open, with `occupancy` and `car_in` unchanged.
- **Simultaneous entry and exit at occupancy 2**: `enter_done` and `exit_done` on the same edge. Check `occupancy`=2 and `car_in` +1.
- **Hour scheduling**: admit 2 cars in hour 0 and 1 car in hour 3, then 8 `hour_tick` pulses. Check `hour`=7, `day_end`=1, entry blocked while exit still works. Readout gives `rd_data` 2, 0, 0, 1 for addresses 0–3, each one cycle after `rd_addr` is applied.
- **Reset mid-operation**: with the entry gate open and `occupancy`=2, assert `reset` together with `enter_done`. Check all outputs at reset values on the next cycle.
